// File: rtl/pn_ber_checker.sv
// PN (m-sequence) bit-error-rate checker: self-synchronises a local LFSR replica to the
// received stream, counts bits/errors while locked and drops lock on a bad error window.
module pn_ber_checker #(
  parameter int LFSR_WIDTH  = 7,
  parameter int TAP_A       = 6,
  parameter int TAP_B       = 5,
  parameter int LOCK_THRESH = 32,
  parameter int WINDOW      = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_i,
  input  logic                 bit_valid_i,
  input  logic                 clear_i,
  output logic                 locked_o,
  output logic                 err_o,
  output logic                 loss_o,
  output logic [CNT_WIDTH-1:0] bit_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int LOAD_W  = $clog2(LFSR_WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_THRESH + 1);
  localparam int WIN_W   = $clog2(WINDOW + 1);

  localparam logic [LOAD_W-1:0]    LOAD_LAST  = LOAD_W'(LFSR_WIDTH - 1);
  localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(LOCK_THRESH - 1);
  localparam logic [WIN_W-1:0]     WIN_LAST   = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0]     LOSS_LIMIT = WIN_W'(LOSS_THRESH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_CHECK,
    ST_LOCKED
  } state_t;

  state_t                 state_q,    state_d;
  logic [LFSR_WIDTH-1:0]  lfsr_q,     lfsr_d;
  logic [LOAD_W-1:0]      loadCnt_q,  loadCnt_d;
  logic [MATCH_W-1:0]     matchCnt_q, matchCnt_d;
  logic [WIN_W-1:0]       winBits_q,  winBits_d;
  logic [WIN_W-1:0]       winErrs_q,  winErrs_d;
  logic                   locked_q,   locked_d;
  logic                   err_q,      err_d;
  logic                   loss_q,     loss_d;
  logic [CNT_WIDTH-1:0]   bitCnt_q,   bitCnt_d;
  logic [CNT_WIDTH-1:0]   errCnt_q,   errCnt_d;

  logic                   expBit;
  logic                   mismatch;
  logic                   countBit;
  logic                   countErr;
  logic [WIN_W-1:0]       winErrsNext;

  assign expBit      = lfsr_q[TAP_A] ^ lfsr_q[TAP_B];
  assign mismatch    = bit_i ^ expBit;
  assign winErrsNext = winErrs_q + WIN_W'(mismatch);

  // Hunt (LOAD/CHECK) shifts received bits in; LOCKED free-runs on its own prediction
  // so a corrupted input bit cannot poison later predictions.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    loadCnt_d  = loadCnt_q;
    matchCnt_d = matchCnt_q;
    winBits_d  = winBits_q;
    winErrs_d  = winErrs_q;
    err_d      = 1'b0;
    loss_d     = 1'b0;
    countBit   = 1'b0;
    countErr   = 1'b0;

    if (bit_valid_i) begin
      case (state_q)
        ST_LOAD: begin
          lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], bit_i};
          if (loadCnt_q == LOAD_LAST) begin
            state_d    = ST_CHECK;
            loadCnt_d  = '0;
            matchCnt_d = '0;
          end else begin
            loadCnt_d = loadCnt_q + LOAD_W'(1);
          end
        end
        ST_CHECK: begin
          lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], bit_i};
          if (mismatch) begin
            state_d   = ST_LOAD;
            loadCnt_d = '0;
          end else if (matchCnt_q == MATCH_LAST) begin
            state_d   = ST_LOCKED;
            winBits_d = '0;
            winErrs_d = '0;
          end else begin
            matchCnt_d = matchCnt_q + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          lfsr_d   = {lfsr_q[LFSR_WIDTH-2:0], expBit};
          countBit = 1'b1;
          countErr = mismatch;
          err_d    = mismatch;
          // The window verdict includes the error on its final bit.
          if (winBits_q == WIN_LAST) begin
            if (winErrsNext >= LOSS_LIMIT) begin
              loss_d    = 1'b1;
              state_d   = ST_LOAD;
              loadCnt_d = '0;
            end
            winBits_d = '0;
            winErrs_d = '0;
          end else begin
            winBits_d = winBits_q + WIN_W'(1);
            winErrs_d = winErrsNext;
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end

    locked_d = (state_d == ST_LOCKED);

    // A clear beats a same-cycle increment; each counter sticks at all-ones.
    bitCnt_d = bitCnt_q;
    errCnt_d = errCnt_q;
    if (clear_i) begin
      bitCnt_d = '0;
      errCnt_d = '0;
    end else begin
      if (countBit && (bitCnt_q != CNT_MAX)) bitCnt_d = bitCnt_q + CNT_WIDTH'(1);
      if (countErr && (errCnt_q != CNT_MAX)) errCnt_d = errCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOAD;
      lfsr_q     <= '0;
      loadCnt_q  <= '0;
      matchCnt_q <= '0;
      winBits_q  <= '0;
      winErrs_q  <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      loss_q     <= 1'b0;
      bitCnt_q   <= '0;
      errCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      loadCnt_q  <= loadCnt_d;
      matchCnt_q <= matchCnt_d;
      winBits_q  <= winBits_d;
      winErrs_q  <= winErrs_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      loss_q     <= loss_d;
      bitCnt_q   <= bitCnt_d;
      errCnt_q   <= errCnt_d;
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign loss_o    = loss_q;
  assign bit_cnt_o = bitCnt_q;
  assign err_cnt_o = errCnt_q;

endmodule

// File: tb/tb_pn_ber_checker.sv
// Self-checking bench for pn_ber_checker: two instances (32-bit and 4-bit counters) run the
// same randomized PN/non-PN traffic and are compared every cycle with a bit-history model.
module tb_pn_ber_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bitIn = 1'b0;
  logic        bitValid = 1'b0;
  logic        clearIn = 1'b0;

  logic        lockedBig, errBig, lossBig;
  logic [31:0] bitCntBig, errCntBig;
  logic        lockedSmall, errSmall, lossSmall;
  logic [3:0]  bitCntSmall, errCntSmall;

  int compareCount = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  pn_ber_checker dutBig (
    .clk(clk), .rst(rst), .bit_i(bitIn), .bit_valid_i(bitValid), .clear_i(clearIn),
    .locked_o(lockedBig), .err_o(errBig), .loss_o(lossBig),
    .bit_cnt_o(bitCntBig), .err_cnt_o(errCntBig)
  );

  pn_ber_checker #(.CNT_WIDTH(4)) dutSmall (
    .clk(clk), .rst(rst), .bit_i(bitIn), .bit_valid_i(bitValid), .clear_i(clearIn),
    .locked_o(lockedSmall), .err_o(errSmall), .loss_o(lossSmall),
    .bit_cnt_o(bitCntSmall), .err_cnt_o(errCntSmall)
  );

  // Reference model: the last 7 bits the checker holds (hist[0] oldest), a hunt/lock phase,
  // and plain integer counters with saturation applied arithmetically.
  bit     pnSeq[127];
  bit     hist[$];
  int     phase;
  int     loadCount, matchCount, winBits, winErrs;
  longint bits32, errs32, bits4, errs4;
  bit     expLocked, expErr, expLoss;

  int     validCount, lockAt, lossAt, lossPulses, pnPos;
  bit     prevLocked, everLocked;

  function automatic longint satInc(input longint v, input longint maxVal);
    return (v >= maxVal) ? maxVal : v + 1;
  endfunction

  task automatic modelReset();
    hist = {};
    for (int i = 0; i < 7; i++) hist.push_back(1'b0);
    phase = 0; loadCount = 0; matchCount = 0; winBits = 0; winErrs = 0;
    bits32 = 0; errs32 = 0; bits4 = 0; errs4 = 0;
    expLocked = 0; expErr = 0; expLoss = 0;
    validCount = 0; lockAt = -1; lossAt = -1; lossPulses = 0;
    prevLocked = 0; everLocked = 0;
  endtask

  task automatic pushHist(input bit x);
    hist.push_back(x);
    void'(hist.pop_front());
  endtask

  task automatic modelStep(input bit b, input bit v, input bit c);
    bit wasLocked;
    bit e;
    wasLocked = (phase == 2);
    expErr = 0;
    expLoss = 0;
    if (v) begin
      e = hist[0] ^ hist[1];
      if (phase == 0) begin
        pushHist(b);
        loadCount++;
        if (loadCount == 7) begin phase = 1; matchCount = 0; end
      end else if (phase == 1) begin
        pushHist(b);
        if (b != e) begin
          phase = 0; loadCount = 0;
        end else begin
          matchCount++;
          if (matchCount == 32) begin phase = 2; winBits = 0; winErrs = 0; end
        end
      end else begin
        pushHist(e);
        if (b != e) begin expErr = 1; winErrs++; end
        if (winBits == 63) begin
          if (winErrs >= 8) begin expLoss = 1; phase = 0; loadCount = 0; end
          winBits = 0; winErrs = 0;
        end else begin
          winBits++;
        end
      end
    end
    if (c) begin
      bits32 = 0; errs32 = 0; bits4 = 0; errs4 = 0;
    end else if (v && wasLocked) begin
      bits32 = satInc(bits32, 64'hFFFF_FFFF);
      bits4  = satInc(bits4, 15);
      if (expErr) begin
        errs32 = satInc(errs32, 64'hFFFF_FFFF);
        errs4  = satInc(errs4, 15);
      end
    end
    expLocked = (phase == 2);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit b, input bit v, input bit c);
    bitIn = b;
    bitValid = v;
    clearIn = c;
    @(posedge clk);
    #1;
    modelStep(b, v, c);
    if (v) validCount++;
    checkOutput("lockedBig", lockedBig, expLocked);
    checkOutput("errBig", errBig, expErr);
    checkOutput("lossBig", lossBig, expLoss);
    checkOutput("bitCntBig", bitCntBig, bits32);
    checkOutput("errCntBig", errCntBig, errs32);
    checkOutput("lockedSmall", lockedSmall, expLocked);
    checkOutput("errSmall", errSmall, expErr);
    checkOutput("lossSmall", lossSmall, expLoss);
    checkOutput("bitCntSmall", bitCntSmall, bits4);
    checkOutput("errCntSmall", errCntSmall, errs4);
    if (lockedBig && !prevLocked) lockAt = validCount;
    if (lockedBig) everLocked = 1;
    if (lossBig) begin lossAt = validCount; lossPulses++; end
    prevLocked = lockedBig;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    bitIn = 1'($urandom);
    bitValid = 1'b1;
    clearIn = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    rst = 1'b0;
    bitValid = 1'b0;
    checkOutput("rstLocked", lockedBig, 0);
    checkOutput("rstErr", errBig, 0);
    checkOutput("rstLoss", lossBig, 0);
    checkOutput("rstBitCnt", bitCntBig, 0);
    checkOutput("rstErrCnt", errCntBig, 0);
    checkOutput("rstLockedSmall", lockedSmall, 0);
    checkOutput("rstBitCntSmall", bitCntSmall, 0);
    checkOutput("rstErrCntSmall", errCntSmall, 0);
  endtask

  task automatic sendPn(input int n, input bit invert);
    for (int i = 0; i < n; i++) begin
      applyStimulus(pnSeq[pnPos % 127] ^ invert, 1'b1, 1'b0);
      pnPos++;
    end
  endtask

  task automatic alignToWindowStart();
    for (int i = 0; i < 70 && winBits != 0; i++) sendPn(1, 1'b0);
    checkOutput("windowAligned", 64'(winBits), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 7; i++) pnSeq[i] = 1'b1;
    for (int i = 7; i < 127; i++) pnSeq[i] = pnSeq[i-7] ^ pnSeq[i-6];
    modelReset();
    pnPos = 0;

    // Clean PN7 from reset: lock point and 1000 locked bits.
    applyReset();
    sendPn(39 + 1000, 1'b0);
    checkOutput("lockPoint", 64'(lockAt), 39);
    checkOutput("bitCnt1000", bitCntBig, 1000);
    checkOutput("errCntClean", errCntBig, 0);
    checkOutput("bitCntSaturated", bitCntSmall, 15);

    // Single inverted bit while locked; the next bit must check clean.
    sendPn(1, 1'b1);
    checkOutput("singleErrPulse", errBig, 1);
    checkOutput("singleErrCnt", errCntBig, 1);
    checkOutput("stillLocked", lockedBig, 1);
    sendPn(1, 1'b0);
    checkOutput("noPropagation", errBig, 0);

    // Seven errors in one window stays locked; eight forces loss then a 39-bit relock.
    alignToWindowStart();
    sendPn(5, 1'b0);
    sendPn(7, 1'b1);
    sendPn(64, 1'b0);
    checkOutput("sevenErrNoLoss", 64'(lossPulses), 0);
    checkOutput("sevenErrLocked", lockedBig, 1);
    alignToWindowStart();
    sendPn(10, 1'b0);
    sendPn(8, 1'b1);
    sendPn(64 + 39 + 5, 1'b0);
    checkOutput("eightErrLoss", 64'(lossPulses), 1);
    checkOutput("relockDistance", 64'(lockAt - lossAt), 39);

    // Small-counter saturation, clear beating an increment, err pulse under clear.
    sendPn(20, 1'b0);
    checkOutput("smallSat20", bitCntSmall, 15);
    applyStimulus(pnSeq[pnPos % 127] ^ 1'b1, 1'b1, 1'b1);
    pnPos++;
    checkOutput("clearBitCnt", bitCntSmall, 0);
    checkOutput("clearErrCnt", errCntBig, 0);
    checkOutput("clearErrPulse", errBig, 1);
    sendPn(3, 1'b0);
    checkOutput("afterClear3", bitCntSmall, 3);
    applyReset();

    // Random non-PN bits: hunting only, counters untouched.
    for (int i = 0; i < 300; i++) applyStimulus(1'($urandom), 1'b1, 1'b0);
    checkOutput("randomNeverLocked", 64'(everLocked), 0);
    checkOutput("randomBitCnt", bitCntBig, 0);
    checkOutput("randomErrCnt", errCntBig, 0);

    // One-in-three valid cycles with junk and occasional clears on idle cycles.
    applyReset();
    pnPos = $urandom_range(0, 126);
    for (int c = 0; c < 3 * 80; c++) begin
      if (c % 3 == 0) begin
        applyStimulus(pnSeq[pnPos % 127], 1'b1, 1'b0);
        pnPos++;
      end else begin
        applyStimulus(1'($urandom), 1'b0, ($urandom_range(0, 7) == 0));
      end
    end
    checkOutput("sparseLockPoint", 64'(lockAt), 39);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
